burst_decoder: RTL

Parametrised, registered one-hot address decoder with a valid/ready request port and burst sequencing. A single accepted request drives one output line, or a run of consecutive lines with wrap-around. It sits in front of register-file and memory-bank write-enable fan-out. It generalises the 2-to-4 decoder to 2^ADDR_WIDTH outputs and adds burst, stall and handshake behaviour.

---
 rtl/burst_decoder.sv | 108 ++++++++++
 1 files changed

// File: rtl/burst_decoder.sv
// burst_decoder
//   Registered one-hot address decoder with a valid/ready request port and
//   burst sequencing. An accepted request issues one beat per unstalled cycle
//   on `out`, starting at req_addr and running for req_len+1 consecutive lines.
//   Line numbers wrap around from N_OUT-1 back to 0.
//
//   Optional feature: define BURST_DECODER_B2B_EN to accept a new request on
//   the last beat of a burst. This gives zero-bubble streaming of requests.
//
// Parameters
//   ADDR_WIDTH  address width (1..6); N_OUT = 2**ADDR_WIDTH output lines
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle
//   req_addr   first output line of the burst
//   req_len    burst length minus one
//   stall      pauses an active burst (acts on the current cycle)
//   out        one-hot beat, zero when no beat is issued
//   out_valid  out carries a beat
//   out_last   current beat is the final beat of the burst
//   busy       burst in progress
module burst_decoder #(
  parameter  int ADDR_WIDTH = 2,
  localparam int N_OUT      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_len,
  input  logic                  stall,
  output logic [N_OUT-1:0]      out,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out         = '0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    req_ready   = 1'b0;
    busy        = (state_q == BURST);

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      BURST: begin
        // Beats are decoded from the registered line number. Only stall
        // gates the current cycle.
        if (!stall) begin
          out[cur_addr_q] = 1'b1;
          out_valid       = 1'b1;
          out_last        = (remaining_q == '0);
          if (remaining_q == '0) begin
            state_d = IDLE;
`ifdef BURST_DECODER_B2B_EN
            req_ready = 1'b1;
`else
            req_ready = 1'b0;
`endif
          end else begin
            cur_addr_d  = cur_addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the end-of-burst return to IDLE.
    // This is what chains bursts in back-to-back mode.
    if (req_valid && req_ready) begin
      cur_addr_d  = req_addr;
      remaining_d = req_len;
      state_d     = BURST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
    end
  end

endmodule
